gen_regs_sb: RTL

- Parametrised general-purpose register file for the pipelined CPU, generalised in data width, register count and number of read ports.
- Writeback keeps partial-word merge for unaligned left/right loads at any power-of-two byte width, plus write-to-read forwarding.
- Adds a per-register busy scoreboard: decode sets a bit when it issues a producer, writeback clears it, so hazard logic can stall on pending results.

---
 rtl/gen_regs_sb_if.sv | 27 ++
 rtl/gen_regs_sb.sv | 56 +++++
 2 files changed

// File: rtl/gen_regs_sb_if.sv
// gen_regs_sb_if: writeback, issue and read-port bundle for the gen_regs_sb register file
interface gen_regs_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD = 3,
    parameter int OFF_W = 2
);
    logic RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] Write;
    logic [1:0] MergeMode;
    logic [OFF_W-1:0] ByteOff;
    logic IssueValid;
    logic [ADDR_W-1:0] IssueReg;
    logic [NRD*ADDR_W-1:0] ReadReg;
    logic [NRD*DATA_W-1:0] ReadData;
    logic [NRD-1:0] ReadBusy;
    logic AnyBusy;
    modport master (
        output RegWrite, WriteReg, Write, MergeMode, ByteOff, IssueValid, IssueReg, ReadReg,
        input ReadData, ReadBusy, AnyBusy
    );
    modport slave (
        input RegWrite, WriteReg, Write, MergeMode, ByteOff, IssueValid, IssueReg, ReadReg,
        output ReadData, ReadBusy, AnyBusy
    );
endinterface

// File: rtl/gen_regs_sb.sv
// gen_regs_sb: parametrised register file with partial-word load merge,
// write-to-read forwarding and a per-register busy scoreboard
module gen_regs_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD = 3,
    parameter int OFF_W = 2
) (
    input logic clk,
    input logic reset,
    gen_regs_sb_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] ONES = '1;
    if (DATA_W % 8 != 0 || NB == 0 || (NB & (NB - 1)) != 0 || OFF_W != $clog2(NB)) begin : g_bad
        $fatal(1, "gen_regs_sb: illegal DATA_W/OFF_W combination");
    end
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0] old, lmask, rmask, wd;
    logic wr_en;
    assign wr_en = bus.RegWrite && bus.WriteReg != '0;
    assign old = regs_q[bus.WriteReg];
    // NB is a power of two, so NB-1-ByteOff is simply ~ByteOff
    assign lmask = ONES << {~bus.ByteOff, 3'b000};
    assign rmask = ONES >> {bus.ByteOff, 3'b000};
    always_comb
        wd = bus.MergeMode == 2'b01 ? (bus.Write << {~bus.ByteOff, 3'b000}) | (old & ~lmask)
           : bus.MergeMode == 2'b10 ? (bus.Write >> {bus.ByteOff, 3'b000}) | (old & ~rmask)
           : bus.Write;
    // set after clear so a newer producer keeps ownership of the register
    always_comb begin
        busy_d = busy_q;
        if (wr_en) busy_d[bus.WriteReg] = 1'b0;
        if (bus.IssueValid && bus.IssueReg != '0) busy_d[bus.IssueReg] = 1'b1;
        busy_d[0] = 1'b0;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            if (wr_en) regs_q[bus.WriteReg] <= wd;
        end
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic fwd;
        assign idx = bus.ReadReg[p*ADDR_W +: ADDR_W];
        assign fwd = bus.RegWrite && idx == bus.WriteReg;
        assign bus.ReadData[p*DATA_W +: DATA_W] = idx == '0 ? '0 : fwd ? wd : regs_q[idx];
        assign bus.ReadBusy[p] = busy_q[idx] && !fwd;
    end
    assign bus.AnyBusy = |busy_q;
endmodule
